// File: rtl/mprj_checkpoint_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : mprj_checkpoint_monitor
//  Purpose  : In-order checkpoint matcher for a watched GPIO slice, with a
//             glitch filter, per-entry tolerance and per-checkpoint timeout.
//             Optional timestamping is enabled by defining CKMON_TIMESTAMP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mprj_checkpoint_monitor #(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 8,
    parameter int TOL_W          = 4,
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_W      = 24,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic [WIDTH-1:0]           watch,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [WIDTH-1:0]           prog_value,
    input  logic [TOL_W-1:0]           prog_tol,
    input  logic [$clog2(DEPTH):0]     seq_len,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [$clog2(DEPTH):0]     cur_idx,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    output logic                       match_pulse
`ifdef CKMON_TIMESTAMP_EN
    ,
    output logic [31:0]                last_stamp
`endif
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_IW = C_AW + 1;
    localparam int C_SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [C_SW-1:0] C_STABLE = C_SW'(STABLE_CYCLES);
    localparam bit C_TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] C_TO_LAST =
        C_TO_EN ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [C_IW-1:0]        seq_len_q, seq_len_d;
    logic [C_IW-1:0]        cur_idx_q, cur_idx_d;
    logic [C_AW-1:0]        fail_idx_q, fail_idx_d;
    logic [TIMEOUT_W-1:0]   tcnt_q, tcnt_d;
    logic [WIDTH-1:0]       prev_q, prev_d;
    logic [C_SW-1:0]        stable_cnt_q, stable_cnt_d;
    logic                   match_pulse_q, match_pulse_d;
    logic [WIDTH-1:0]       tbl_val_q [DEPTH];
    logic [WIDTH-1:0]       tbl_val_d [DEPTH];
    logic [TOL_W-1:0]       tbl_tol_q [DEPTH];
    logic [TOL_W-1:0]       tbl_tol_d [DEPTH];

    logic [WIDTH-1:0]       w_exp_val;
    logic [TOL_W-1:0]       w_exp_tol;
    logic [WIDTH-1:0]       w_diff;
    logic                   w_eligible;
    logic                   w_hit;
    logic                   w_start_ok;
    logic [C_IW-1:0]        w_idx_inc;

    // Table is frozen while a sequence runs so the awaited entry cannot move.
    always_comb begin
        tbl_val_d = tbl_val_q;
        tbl_tol_d = tbl_tol_q;
        if (prog_we && (state_q != S_RUN)) begin
            tbl_val_d[prog_addr] = prog_value;
            tbl_tol_d[prog_addr] = prog_tol;
        end
    end

    // stable_cnt counts consecutive identical samples including the current one.
    always_comb begin
        prev_d       = watch;
        stable_cnt_d = stable_cnt_q;
        if (watch != prev_q) begin
            stable_cnt_d = C_SW'(1);
        end else if (stable_cnt_q != C_STABLE) begin
            stable_cnt_d = stable_cnt_q + C_SW'(1);
        end
    end

    assign w_eligible = (stable_cnt_d == C_STABLE);
    assign w_exp_val  = tbl_val_q[cur_idx_q[C_AW-1:0]];
    assign w_exp_tol  = tbl_tol_q[cur_idx_q[C_AW-1:0]];
    assign w_diff     = (watch >= w_exp_val) ? (watch - w_exp_val)
                                             : (w_exp_val - watch);
    assign w_hit      = w_eligible && (w_diff <= WIDTH'(w_exp_tol));
    assign w_start_ok = start && !abort && (state_q != S_RUN);
    assign w_idx_inc  = cur_idx_q + C_IW'(1);

    always_comb begin
        state_d       = state_q;
        seq_len_d     = seq_len_q;
        cur_idx_d     = cur_idx_q;
        fail_idx_d    = fail_idx_q;
        tcnt_d        = tcnt_q;
        match_pulse_d = 1'b0;
        if (abort) begin
            state_d    = S_IDLE;
            cur_idx_d  = '0;
            fail_idx_d = '0;
            tcnt_d     = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (w_hit) begin
                        match_pulse_d = 1'b1;
                        cur_idx_d     = w_idx_inc;
                        tcnt_d        = '0;
                        if (w_idx_inc == seq_len_q) begin
                            state_d = S_PASS;
                        end
                    end else if (C_TO_EN) begin
                        if (tcnt_q == C_TO_LAST) begin
                            state_d    = S_FAIL;
                            fail_idx_d = cur_idx_q[C_AW-1:0];
                        end else begin
                            tcnt_d = tcnt_q + TIMEOUT_W'(1);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        seq_len_d  = seq_len;
                        cur_idx_d  = '0;
                        fail_idx_d = '0;
                        tcnt_d     = '0;
                        state_d    = (seq_len == '0) ? S_PASS : S_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q       <= S_IDLE;
            seq_len_q     <= '0;
            cur_idx_q     <= '0;
            fail_idx_q    <= '0;
            tcnt_q        <= '0;
            prev_q        <= '0;
            stable_cnt_q  <= '0;
            match_pulse_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_val_q[i] <= '0;
                tbl_tol_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            seq_len_q     <= seq_len_d;
            cur_idx_q     <= cur_idx_d;
            fail_idx_q    <= fail_idx_d;
            tcnt_q        <= tcnt_d;
            prev_q        <= prev_d;
            stable_cnt_q  <= stable_cnt_d;
            match_pulse_q <= match_pulse_d;
            tbl_val_q     <= tbl_val_d;
            tbl_tol_q     <= tbl_tol_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign cur_idx     = cur_idx_q;
    assign fail_idx    = fail_idx_q;
    assign match_pulse = match_pulse_q;

`ifdef CKMON_TIMESTAMP_EN
    logic [31:0] stamp_cnt_q, stamp_cnt_d;
    logic [31:0] last_stamp_q, last_stamp_d;

    // Stamp is the counter value seen during the match_pulse cycle.
    always_comb begin
        stamp_cnt_d  = w_start_ok ? 32'd0 : (stamp_cnt_q + 32'd1);
        last_stamp_d = last_stamp_q;
        if (abort) begin
            last_stamp_d = '0;
        end else if (match_pulse_d) begin
            last_stamp_d = stamp_cnt_d;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            stamp_cnt_q  <= '0;
            last_stamp_q <= '0;
        end else begin
            stamp_cnt_q  <= stamp_cnt_d;
            last_stamp_q <= last_stamp_d;
        end
    end

    assign last_stamp = last_stamp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mprj_checkpoint_monitor.sv
`default_nettype none
// Self-checking bench for mprj_checkpoint_monitor: tolerance vector table,
// scoreboard on match_pulse, and hand-written multi-cycle corner sequences.
module tb_mprj_checkpoint_monitor;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int TOL_W = 4;
    localparam int AW    = 3;

    logic              clock = 1'b0;
    logic              resetb;
    logic [WIDTH-1:0]  watch;
    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [WIDTH-1:0]  prog_value;
    logic [TOL_W-1:0]  prog_tol;
    logic [AW:0]       seq_len;
    logic              start;
    logic              abort;
    logic              busy;
    logic              pass;
    logic              fail;
    logic [AW:0]       cur_idx;
    logic [AW-1:0]     fail_idx;
    logic              match_pulse;
`ifdef CKMON_TIMESTAMP_EN
    logic [31:0]       last_stamp;
`endif

    mprj_checkpoint_monitor #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TOL_W(TOL_W), .STABLE_CYCLES(2),
        .TIMEOUT_W(24), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .resetb(resetb), .watch(watch),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_value(prog_value),
        .prog_tol(prog_tol), .seq_len(seq_len), .start(start), .abort(abort),
        .busy(busy), .pass(pass), .fail(fail), .cur_idx(cur_idx),
        .fail_idx(fail_idx), .match_pulse(match_pulse)
`ifdef CKMON_TIMESTAMP_EN
        , .last_stamp(last_stamp)
`endif
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;
    int exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] val;
        logic [TOL_W-1:0] tol;
        logic [WIDTH-1:0] w;
        bit               hit;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic prog(input logic [AW-1:0] a, input logic [WIDTH-1:0] v, input logic [TOL_W-1:0] t);
        prog_we = 1'b1; prog_addr = a; prog_value = v; prog_tol = t;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic start_seq(input logic [AW:0] n);
        seq_len = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Scoreboard: every match_pulse must correspond to an expected cur_idx.
    always @(negedge clock) begin
        if (resetb && match_pulse) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_match_pulse: got cur_idx %0d expected no pulse", cur_idx);
            end else begin
                chk("match_cur_idx", 32'(cur_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        vecs[0]  = '{16'h1DCD, 4'd1,  16'h1DCF, 1'b0};
        vecs[1]  = '{16'h1DCD, 4'd1,  16'h1DCC, 1'b1};
        vecs[2]  = '{16'h1DCD, 4'd1,  16'h1DCE, 1'b1};
        vecs[3]  = '{16'h0000, 4'd2,  16'hFFFF, 1'b0};
        vecs[4]  = '{16'h0000, 4'd2,  16'h0002, 1'b1};
        vecs[5]  = '{16'hFFFF, 4'd3,  16'h0001, 1'b0};
        vecs[6]  = '{16'hFFFF, 4'd3,  16'hFFFC, 1'b1};
        vecs[7]  = '{16'h8000, 4'd15, 16'h7FF1, 1'b1};
        vecs[8]  = '{16'h8000, 4'd15, 16'h7FF0, 1'b0};
        vecs[9]  = '{16'h00AA, 4'd0,  16'h00AA, 1'b1};
        vecs[10] = '{16'h00AB, 4'd0,  16'h00AA, 1'b0};

        resetb = 1'b0; watch = '0; prog_we = 1'b0; prog_addr = '0;
        prog_value = '0; prog_tol = '0; seq_len = '0; start = 1'b0; abort = 1'b0;
        tick(2);
        chk("reset_busy", busy, 0);
        chk("reset_pass", pass, 0);
        chk("reset_fail", fail, 0);
        chk("reset_cur_idx", cur_idx, 0);
        chk("reset_fail_idx", fail_idx, 0);
        chk("reset_match_pulse", match_pulse, 0);
        resetb = 1'b1;
        tick();

        // Tolerance table: one entry, seq_len=1, watch applied with start.
        for (int i = 0; i < 11; i++) begin
            do_abort();
            prog(0, vecs[i].val, vecs[i].tol);
            watch = vecs[i].w;
            if (vecs[i].hit) exp_q.push_back(1);
            start_seq(1);
            tick(4);
            chk($sformatf("vec%0d_pass", i), pass, 32'(vecs[i].hit));
            chk($sformatf("vec%0d_fail", i), fail, 0);
            chk($sformatf("vec%0d_cur_idx", i), cur_idx, 32'(vecs[i].hit));
        end

        // Basic three-entry sequence.
        do_abort();
        prog(0, 16'hAB40, 0);
        prog(1, 16'h1968, 1);
        prog(2, 16'hAB51, 0);
        watch = 16'hAB40;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        start_seq(3);
        chk("basic_busy", busy, 1);
        tick(5); watch = 16'h1969;
        tick(5); watch = 16'hAB51;
        tick(5);
        chk("basic_pass", pass, 1);
        chk("basic_fail", fail, 0);
        chk("basic_cur_idx", cur_idx, 3);
        chk("basic_busy_done", busy, 0);

        // Glitch filter and latency.
        do_abort();
        prog(0, 16'h00AA, 0);
        watch = 16'h0000;
        start_seq(1);
        tick(); watch = 16'h00AA;
        tick(); watch = 16'h0000;
        tick(3);
        chk("glitch_pass", pass, 0);
        chk("glitch_busy", busy, 1);
        exp_q.push_back(1);
        watch = 16'h00AA;
        tick();
        chk("latency_early", match_pulse, 0);
        tick();
        chk("latency_pulse", match_pulse, 1);
        chk("latency_pass", pass, 1);

        // Timeout 16 cycles after the entry-0 match.
        do_abort();
        prog(0, 16'h0100, 0);
        prog(1, 16'h0200, 0);
        watch = 16'h0100;
        exp_q.push_back(1);
        start_seq(2);
        tick();
        chk("to_first_match", match_pulse, 1);
        tick(15);
        chk("to_not_yet", fail, 0);
        tick();
        chk("to_fail", fail, 1);
        chk("to_fail_idx", fail_idx, 1);
        chk("to_pass", pass, 0);
        chk("to_busy", busy, 0);

        // Match landing on the timeout cycle wins.
        do_abort();
        exp_q.push_back(1);
        start_seq(2);
        tick(15);
        watch = 16'h0200;
        exp_q.push_back(2);
        tick();
        chk("race_no_fail_early", fail, 0);
        tick();
        chk("race_pulse", match_pulse, 1);
        chk("race_pass", pass, 1);
        chk("race_fail", fail, 0);

        // seq_len = 0.
        do_abort();
        start_seq(0);
        chk("len0_pass", pass, 1);
        chk("len0_busy", busy, 0);
        chk("len0_cur_idx", cur_idx, 0);

        // Abort mid-RUN, and abort overriding start.
        watch = 16'h0100;
        exp_q.push_back(1);
        start_seq(2);
        tick(3);
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_idx", cur_idx, 1);
        do_abort();
        chk("abort_busy", busy, 0);
        chk("abort_cur_idx", cur_idx, 0);
        chk("abort_pass", pass, 0);
        abort = 1'b1; start = 1'b1; seq_len = 2;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_over_start", busy, 0);

        // prog_we during RUN is ignored.
        watch = 16'h0000;
        tick(2);
        start_seq(1);
        tick();
        prog_we = 1'b1; prog_addr = 0; prog_value = 16'h0000; prog_tol = 0;
        tick();
        prog_we = 1'b0;
        tick(4);
        chk("we_run_busy", busy, 1);
        chk("we_run_pass", pass, 0);
        do_abort();
        watch = 16'h0100;
        exp_q.push_back(1);
        start_seq(1);
        tick(2);
        chk("we_run_table_kept", pass, 1);

        // Identical consecutive entries.
        do_abort();
        prog(0, 16'h1234, 0);
        prog(1, 16'h1234, 0);
        watch = 16'h1234;
        tick(3);
        exp_q.push_back(1); exp_q.push_back(2);
        start_seq(2);
        tick();
        chk("dup_first_pulse", match_pulse, 1);
        chk("dup_first_idx", cur_idx, 1);
        chk("dup_not_pass_yet", pass, 0);
        tick();
        chk("dup_second_pulse", match_pulse, 1);
        chk("dup_second_idx", cur_idx, 2);
        chk("dup_pass", pass, 1);

        // Asynchronous reset mid-RUN, then table is back to zero.
        do_abort();
        watch = 16'h0000;
        start_seq(2);
        tick(2);
        chk("rst_pre_busy", busy, 1);
        resetb = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pass_fail", {pass, fail}, 0);
        chk("rst_cur_idx", cur_idx, 0);
        chk("rst_match_pulse", match_pulse, 0);
        tick();
        resetb = 1'b1;
        tick();
        exp_q.push_back(1);
        start_seq(1);
        tick();
        chk("rst_table_zero", pass, 1);

        tick(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mprj_checkpoint_monitor.md
Name: mprj_checkpoint_monitor

Overview:
Parametrised checkpoint-sequence monitor for the user-project GPIO bus. It watches a WIDTH-bit slice of mprj_io and matches it, in order, against a programmable table of expected values. Each table entry carries its own +/- tolerance to absorb small RTL/GL count differences. A glitch filter and a per-checkpoint timeout drive pass/fail flags, which status logic and the DV harness consume.

Parameters:
WIDTH, 16, width of watched bus and of expected values
DEPTH, 8, number of table entries (power of 2, >=2)
TOL_W, 4, width of per-entry tolerance
STABLE_CYCLES, 2, consecutive identical samples required before a value is eligible (>=1)
TIMEOUT_W, 24, width of timeout counter
TIMEOUT_CYCLES, 100000, max cycles per checkpoint; 0 disables timeout

Ports:
clock  input  1  sole clock, rising edge
resetb  input  1  asynchronous active-low reset
watch  input  WIDTH  observed bus value (already synchronous to clock)
prog_we  input  1  table write strobe
prog_addr  input  $clog2(DEPTH)  table entry index
prog_value  input  WIDTH  expected value
prog_tol  input  TOL_W  allowed absolute deviation
seq_len  input  $clog2(DEPTH)+1  number of entries to check (0..DEPTH), sampled on start
start  input  1  single-cycle pulse, begin sequence
abort  input  1  return to IDLE, clear flags
busy  output  1  sequence in progress
pass  output  1  all seq_len entries matched (sticky)
fail  output  1  timeout occurred (sticky)
cur_idx  output  $clog2(DEPTH)+1  entry currently awaited / entries matched
fail_idx  output  $clog2(DEPTH)  entry that timed out
match_pulse  output  1  one-cycle pulse per entry matched

Behaviour:
- Reset (async, resetb=0): state IDLE; all outputs 0; table entries 0; stability and timeout counters 0.
- Table writes: accepted only in IDLE, PASS or FAIL; prog_we while busy is ignored. Written entry is visible on the next cycle.
- States: IDLE, RUN, PASS, FAIL.
- IDLE/PASS/FAIL + start:
  - Latch seq_len; clear pass, fail, cur_idx and counters.
  - seq_len=0 -> PASS next cycle, pass=1.
  - Otherwise -> RUN, busy=1.
- start while RUN: ignored.
- abort (any state): -> IDLE next cycle; busy, pass, fail and match_pulse cleared; cur_idx=0. abort overrides start in the same cycle.
- Stability filter:
  - Register previous watch. stable_cnt resets to 1 when watch != prev, else increments, saturating at STABLE_CYCLES.
  - Eligible when stable_cnt == STABLE_CYCLES.
- Match test: diff = (watch >= exp) ? watch-exp : exp-watch, computed unsigned at WIDTH bits, no wrap-around across 0/max. Match when eligible and diff <= zero-extended tol.
- RUN, on match:
  - match_pulse=1 for one cycle; cur_idx increments; timeout counter clears.
  - If the new cur_idx == latched seq_len -> PASS (busy=0, pass=1).
  - The next entry is evaluated no earlier than the following cycle, so one sample never satisfies two entries.
- Timeout:
  - The counter increments every RUN cycle without a match.
  - When it reaches TIMEOUT_CYCLES-1 with no match -> FAIL (busy=0, fail=1, fail_idx=cur_idx).
  - Match and timeout in the same cycle: match wins.
  - TIMEOUT_CYCLES=0: never fails.
- Latency: watch change to match_pulse = STABLE_CYCLES cycles (registered output).
- pass and fail are mutually exclusive and hold until start, abort or reset.

Optional Feature:
CKMON_TIMESTAMP_EN
- Defined:
  - Adds output last_stamp [31:0] and a free-running 32-bit cycle counter that clears on start and wraps silently.
  - On each match_pulse, last_stamp captures the counter value of that cycle. Reset value 0; abort clears it.
- Undefined: port and counter absent; no other behaviour changes.

Test Plan:
- Basic sequence: table {0xAB40,tol0}, {0x1968,tol1}, {0xAB51,tol0}; seq_len=3; STABLE_CYCLES=2; drive 0xAB40, 0x1969, 0xAB51, each held 5 cycles -> three match_pulse, cur_idx 1,2,3, pass=1, fail=0.
- Tolerance boundary: entry {0x1DCD,tol1}; drive 0x1DCF (diff 2) -> no match; then 0x1DCC -> match. Entry {0x0000,tol2} with watch 0xFFFF -> no match (no wrap).
- Glitch filter: entry 0x00AA; drive 0x00AA for 1 cycle, then 0x0000 -> no match. Holding 0x00AA for 2 cycles -> match_pulse exactly 2 cycles after the change.
- Timeout: TIMEOUT_CYCLES=16; match entry 0, then hold a non-matching value -> fail=1 at cycle 16 after the match, fail_idx=1, pass=0. Match arriving in the same cycle as the timeout -> no fail.
- Control corners:
  - seq_len=0 -> pass the cycle after start.
  - abort mid-RUN -> busy=0, cur_idx=0 next cycle.
  - prog_we during RUN -> table unchanged.
  - resetb low mid-RUN -> all outputs 0 immediately.
- Identical consecutive entries: entries 0 and 1 both 0x1234, watch held at 0x1234 -> match_pulse on two separate cycles, never both in one cycle.
